// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver (configurable word length and parity) feeding a show-ahead FIFO
// that stores each word together with its framing and parity error flags.
module uart_rx_fifo_ctrl #(
    parameter int BAUD_RATE   = 115200,
    parameter int CLK_VAL_MHZ = 50,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int FIFO_DEPTH  = 16,
    parameter int AF_LEVEL    = FIFO_DEPTH - 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          almost_full,
    output logic                          overrun,
    input  logic                          clr_overrun
);

    localparam int CLKS_PER_BIT = CLK_VAL_MHZ * 1_000_000 / BAUD_RATE;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam int EW   = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic [1:0]           sync_q;
    logic                 rxs;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 wr_q, wr_d;
    logic                 bit_tick_s;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]        count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic                 push_s, pop_s, drop_s;
    logic [EW-1:0]        head_s;

    // Two-flop synchroniser on the asynchronous serial input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rxs        = sync_q[1];
    assign bit_tick_s = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // Receive FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            wr_q    <= wr_d;
        end
    end

    // Receive FSM next-state: start-bit qualification at mid-bit, then one sample per bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        wr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CW'(CLKS_PER_BIT / 2)) begin
                    cnt_d  = '0;
                    perr_d = 1'b0;
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_tick_s) begin
                    cnt_d  = '0;
                    data_d = {rxs, data_q[DATA_BITS-1:1]};
                    bit_d  = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_STOP;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (bit_tick_s) begin
                    cnt_d   = '0;
                    perr_d  = (((^data_q) ^ rxs) != (PARITY == 1));
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_tick_s) begin
                    cnt_d  = '0;
                    ferr_d = ~rxs;
                    wr_d   = 1'b1;
                    // A good stop bit returns to IDLE at mid-bit for back-to-back resync.
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // A full FIFO still accepts the word when a pop frees the head slot in the same cycle.
    assign pop_s  = rd_en && (count_q != NW'(0));
    assign push_s = wr_q && ((count_q != NW'(FIFO_DEPTH)) || rd_en);
    assign drop_s = wr_q && !push_s;

    // FIFO pointer, level and overrun next-state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + NW'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - NW'(1);
        end else begin
            count_d = count_q;
        end
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; contents need no reset because the read side is gated by rd_valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {perr_q, ferr_q, data_q};
        end
    end

    assign head_s        = mem_q[rd_ptr_q];
    assign rd_valid      = (count_q != NW'(0));
    assign rd_data       = rd_valid ? head_s[DATA_BITS-1:0] : '0;
    assign rd_frame_err  = rd_valid ? head_s[DATA_BITS]     : 1'b0;
    assign rd_parity_err = rd_valid ? head_s[DATA_BITS+1]   : 1'b0;
    assign fifo_count    = count_q;
    assign almost_full   = (count_q >= NW'(AF_LEVEL));
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: 10 clks/bit, 8 data bits, even parity, 16-entry FIFO.
module tb_uart_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_frame_err;
    logic       rd_parity_err;
    logic       rd_valid;
    logic [4:0] fifo_count;
    logic       almost_full;
    logic       overrun;
    logic       clr_overrun;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    uart_rx_fifo_ctrl #(
        .BAUD_RATE  (1_000_000),
        .CLK_VAL_MHZ(10),
        .DATA_BITS  (8),
        .PARITY     (2),
        .FIFO_DEPTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_frame_err (rd_frame_err),
        .rd_parity_err(rd_parity_err),
        .rd_valid     (rd_valid),
        .fifo_count   (fifo_count),
        .almost_full  (almost_full),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one 11-bit frame starting at a negedge; line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input bit pop_at_wr);
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (10) @(negedge clk);
        end
        rx = pbit;
        repeat (10) @(negedge clk);
        rx = sbit;
        repeat (9) @(negedge clk);
        if (pop_at_wr) rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", rd_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_data", rd_data, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single good frame.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("a5_valid", rd_valid, 1);
        chk("a5_data", rd_data, 8'hA5);
        chk("a5_ferr", rd_frame_err, 0);
        chk("a5_perr", rd_parity_err, 0);
        chk("a5_count", fifo_count, 1);
        pop();
        chk("a5_pop_count", fifo_count, 0);
        chk("a5_pop_valid", rd_valid, 0);

        // Parity error, then framing error followed by a held-low line.
        send_frame(8'h03, 1'b1, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("err_count", fifo_count, 2);
        chk("e1_data", rd_data, 8'h03);
        chk("e1_perr", rd_parity_err, 1);
        chk("e1_ferr", rd_frame_err, 0);
        pop();
        chk("e2_data", rd_data, 8'h55);
        chk("e2_ferr", rd_frame_err, 1);
        chk("e2_perr", rd_parity_err, 0);
        pop();
        chk("err_empty", fifo_count, 0);

        // 17 frames with no reads: fill, almost_full threshold, overrun on the 17th.
        for (int i = 0; i <= 16; i++) begin
            v = 8'(i);
            send_frame(v, ^v, 1'b1, 1'b0);
            if (i == 12) chk("af_at13", almost_full, 0);
            if (i == 13) chk("af_at14", almost_full, 1);
            if (i == 15) chk("ovr_at16", overrun, 0);
        end
        repeat (2) @(negedge clk);
        chk("full_count", fifo_count, 16);
        chk("full_af", almost_full, 1);
        chk("full_ovr", overrun, 1);
        for (int i = 0; i < 16; i++) begin
            chk("fill_rd", rd_data, 32'(i));
            pop();
        end
        chk("drain_valid", rd_valid, 0);
        chk("drain_ovr_sticky", overrun, 1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("ovr_clr", overrun, 0);

        // Full FIFO with a pop exactly in the write-pulse cycle.
        for (int i = 0; i < 16; i++) begin
            v = 8'h20 + 8'(i);
            send_frame(v, ^v, 1'b1, 1'b0);
        end
        chk("sim_pre_count", fifo_count, 16);
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        chk("sim_count", fifo_count, 16);
        chk("sim_ovr", overrun, 0);
        chk("sim_head", rd_data, 8'h21);
        for (int i = 0; i < 15; i++) pop();
        chk("sim_last", rd_data, 8'h77);
        pop();
        chk("sim_empty", fifo_count, 0);

        // 3-clk glitch while idle.
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_valid", rd_valid, 0);
        chk("glitch_count", fifo_count, 0);

        // Asynchronous reset during data bit 4 with two entries queued.
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_count", fifo_count, 2);
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (10) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_af", almost_full, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("post_rst_count", fifo_count, 1);
        chk("post_rst_data", rd_data, 8'h12);
        chk("post_rst_ferr", rd_frame_err, 0);
        chk("post_rst_perr", rd_parity_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
Parametrised UART receiver with an integrated receive FIFO. It generalises the byte-only receive path to configurable data bits, optional parity and error reporting. Each received word is stored in the FIFO together with its per-word framing and parity error bits. It presents a show-ahead read interface, a fill level and a sticky overrun flag, and sits between the rx pin and the CPU-side peripheral register block.

Parameters:
BAUD_RATE, 115200, line bit rate.
CLK_VAL_MHZ, 50, clk frequency in MHz. CLKS_PER_BIT = CLK_VAL_MHZ*1_000_000/BAUD_RATE (integer division, must be >= 4).
DATA_BITS, 8, word length, legal 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
FIFO_DEPTH, 16, entries, power of 2, >= 2.
AF_LEVEL, FIFO_DEPTH-2, almost_full threshold.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx  in  1  serial line, idle high, asynchronous to clk
rd_en  in  1  pop request; ignored when rd_valid = 0
rd_data  out  DATA_BITS  head-of-FIFO word (show-ahead)
rd_frame_err  out  1  head word was received with stop bit = 0
rd_parity_err  out  1  head word failed the parity check (always 0 when PARITY = 0)
rd_valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current entries, 0..FIFO_DEPTH
almost_full  out  1  fifo_count >= AF_LEVEL
overrun  out  1  sticky; a received word was dropped because the FIFO was full
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (asynchronous): receive FSM goes to IDLE, bit/clock counters 0, FIFO pointers 0, synchroniser flops 1. Outputs: rd_valid=0, fifo_count=0, almost_full=0, overrun=0, rd_data/rd_frame_err/rd_parity_err=0. Assertion mid-frame abandons the partial word; nothing is written.
- rx passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised signal (rxs).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on rxs = 0 go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2, if rxs = 1 (glitch) return to IDLE; otherwise restart the counter and go to DATA.
  - DATA: sample rxs every CLKS_PER_BIT, LSB first. After DATA_BITS samples go to PARITY if PARITY != 0, else to STOP.
  - PARITY: sample one bit. parity_err = (XOR of data bits and parity bit) != (PARITY == 1).
  - STOP: sample one bit. frame_err = ~rxs. Issue one write pulse in the cycle after the sample.
    - frame_err = 0: go to IDLE immediately, giving half-bit resync margin for back-to-back frames.
    - frame_err = 1: go to BREAK.
  - BREAK: stay until rxs = 1, then go to IDLE. A line held low does not re-trigger.
- FIFO entry = {parity_err, frame_err, data}.
  - Write is accepted when count < FIFO_DEPTH, or when count = FIFO_DEPTH and rd_en = 1 in the same cycle (simultaneous pop frees a slot).
  - Otherwise the word is dropped, overrun is set next cycle, and FIFO contents are unchanged.
- Read: the head entry is visible combinationally from storage whenever rd_valid = 1. rd_en pops at the clock edge, and the next entry appears the following cycle.
- Pop and push in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. count is held explicitly (or derived from pointers one bit wider than the address), never ambiguous between full and empty.
- overrun: if clr_overrun and a new drop occur in the same cycle, the set wins.
- rd_data contents while rd_valid = 0 are don't-care.
- All outputs are registered or derived from registered state; there is no combinational path from rx to any output.
- Latency: the write happens 1 cycle after the mid-stop-bit sample. rd_valid rises the cycle after that write.

Test Plan:
- Bench config for all scenarios: CLK_VAL_MHZ=10, BAUD_RATE=1_000_000 (10 clks/bit), DATA_BITS=8, PARITY=2 (even).
- Single frame 0xA5 with parity bit 0 -> rd_valid rises, rd_data=0xA5, rd_frame_err=0, rd_parity_err=0, fifo_count=1. One rd_en pulse -> count=0, rd_valid=0.
- Frame 0x03 with parity bit 1 (wrong), then frame 0x55 with stop bit 0 -> entry 1: 0x03 with parity_err=1. Entry 2: 0x55 with frame_err=1. FSM waits in BREAK while the line stays low 30 clks; no extra entries are written.
- 17 back-to-back frames 0x00..0x10 with no reads (FIFO_DEPTH=16) -> fifo_count=16, almost_full=1 from count 14, overrun=1 after the 17th frame. Reads return 0x00..0x0F; 0x10 is lost. clr_overrun -> overrun=0.
- FIFO full, and rd_en asserted exactly in the write-pulse cycle of a new frame 0x77 -> no overrun, count stays 16, last entry read out = 0x77.
- 3-clk low glitch on rx while IDLE -> returns to IDLE, no write, rd_valid stays 0.
- rst asserted during DATA bit 4 of frame 0xFF with 2 entries queued -> all outputs reach reset values immediately (asynchronously). After release, a following frame 0x12 is received as the sole entry.
